// File: rtl/hmmm.sv
`default_nettype none
// ============================================================================
// hmmm : multi-cycle HMMM CPU, 16 regs, 256x16 unified RAM, 2 cycles/instr
// Rev 1.0
// ============================================================================
module hmmm (
  input  logic        clk,
  input  logic        rst,
  input  logic        pgrm_addr,
  input  logic        pgrm_data,
  output logic        read,
  output logic        write,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        halt
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [15:0] regs [16];
  logic [15:0] mem  [256];
  logic [7:0]  prog_ptr;

  logic [3:0]  opc;
  logic [3:0]  xi;
  logic [3:0]  yi;
  logic [3:0]  zi;
  logic [7:0]  n;
  logic [15:0] n_sx;
  logic [15:0] rx;
  logic [15:0] ry;
  logic [15:0] rz;
  logic [15:0] ry_dec;
  logic [15:0] ry_inc;

  assign opc    = ir[15:12];
  assign xi     = ir[11:8];
  assign yi     = ir[7:4];
  assign zi     = ir[3:0];
  assign n      = ir[7:0];
  assign n_sx   = {{8{n[7]}}, n};
  assign rx     = regs[xi];
  assign ry     = regs[yi];
  assign rz     = regs[zi];
  assign ry_dec = ry - 16'd1;
  assign ry_inc = ry + 16'd1;

  logic [15:0] fetch_word;
  logic        fetch_is_read;
  assign fetch_word    = mem[pc];
  assign fetch_is_read = (fetch_word[15:12] == 4'h0) && (fetch_word[7:0] == 8'h01);

  // Data-memory read port: N for loadn, rY for loadr, rY-1 for popr.
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  always_comb begin
    rd_addr = n;
    if (opc == 4'h4)
      rd_addr = (ir[1:0] == 2'b10) ? ry_dec[7:0] : ry[7:0];
  end
  assign rd_data = mem[rd_addr];

  logic signed [15:0] sy;
  logic signed [15:0] sz;
  logic signed [15:0] quo;
  logic signed [15:0] rem;
  logic               rz_zero;
  assign sy      = $signed(ry);
  assign sz      = $signed(rz);
  assign rz_zero = (rz == 16'h0000);
  assign quo     = rz_zero ? 16'sd0 : sy / sz;
  assign rem     = rz_zero ? 16'sd0 : sy % sz;

  logic        wb_en;
  logic [15:0] wb_data;
  logic        ptr_en;
  logic [15:0] ptr_data;
  logic        st_en;
  logic [7:0]  st_addr;
  logic        pc_ld;
  logic [7:0]  pc_nxt;
  logic        out_en;
  logic        do_halt;

  always_comb begin
    wb_en    = 1'b0;
    wb_data  = 16'h0000;
    ptr_en   = 1'b0;
    ptr_data = 16'h0000;
    st_en    = 1'b0;
    st_addr  = n;
    pc_ld    = 1'b0;
    pc_nxt   = n;
    out_en   = 1'b0;
    do_halt  = 1'b0;
    case (opc)
      4'h0: begin
        if (ir[7:4] == 4'h0) begin
          case (ir[3:0])
            4'h0: do_halt = (xi == 4'h0);
            4'h1: begin wb_en = 1'b1; wb_data = in; end
            4'h2: out_en = 1'b1;
            4'h3: begin pc_ld = 1'b1; pc_nxt = rx[7:0]; end
            default: ;
          endcase
        end
      end
      4'h1: begin wb_en = 1'b1; wb_data = n_sx; end
      4'h2: begin wb_en = 1'b1; wb_data = rd_data; end
      4'h3: st_en = 1'b1;
      4'h4: begin
        case (ir[3:0])
          4'h0: begin wb_en = 1'b1; wb_data = rd_data; end
          4'h1: begin st_en = 1'b1; st_addr = ry[7:0]; end
          4'h2: begin
            wb_en    = 1'b1;
            wb_data  = rd_data;
            ptr_en   = 1'b1;
            ptr_data = ry_dec;
          end
          4'h3: begin
            st_en    = 1'b1;
            st_addr  = ry[7:0];
            ptr_en   = 1'b1;
            ptr_data = ry_inc;
          end
          default: ;
        endcase
      end
      4'h5: begin wb_en = 1'b1; wb_data = rx + n_sx; end
      4'h6: begin wb_en = 1'b1; wb_data = ry + rz; end
      4'h7: begin wb_en = 1'b1; wb_data = ry - rz; end
      4'h8: begin wb_en = 1'b1; wb_data = ry * rz; end
      4'h9: begin wb_en = 1'b1; wb_data = quo; end
      4'hA: begin wb_en = 1'b1; wb_data = rem; end
      4'hB: begin wb_en = 1'b1; wb_data = {8'h00, pc}; pc_ld = 1'b1; end
      4'hC: pc_ld = (rx == 16'h0000);
      4'hD: pc_ld = (rx != 16'h0000);
      4'hE: pc_ld = !rx[15] && (rx != 16'h0000);
      4'hF: pc_ld = rx[15];
      default: ;
    endcase
  end

  logic st_we;
  assign st_we = (state == EXEC) && st_en && rst;

  // RAM and load pointer survive reset; the loader wins over a CPU store.
  always_ff @(posedge clk) begin
    if (pgrm_data)
      mem[prog_ptr] <= in;
    else if (st_we)
      mem[st_addr] <= rx;
  end

  always_ff @(posedge clk) begin
    if (pgrm_addr)
      prog_ptr <= in[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
      pc    <= 8'h00;
      ir    <= 16'h0000;
      out   <= 16'h0000;
      read  <= 1'b0;
      write <= 1'b0;
      halt  <= 1'b0;
      for (int i = 0; i < 16; i++)
        regs[i] <= 16'h0000;
    end else begin
      case (state)
        FETCH: begin
          ir    <= fetch_word;
          pc    <= pc + 8'd1;
          read  <= fetch_is_read;
          write <= 1'b0;
          state <= EXEC;
        end
        EXEC: begin
          read  <= 1'b0;
          write <= out_en;
          // Pointer write comes second so it wins when X == Y.
          if (wb_en && (xi != 4'h0))
            regs[xi] <= wb_data;
          if (ptr_en && (yi != 4'h0))
            regs[yi] <= ptr_data;
          if (out_en)
            out <= rx;
          if (pc_ld)
            pc <= pc_nxt;
          if (do_halt) begin
            halt  <= 1'b1;
            state <= HALTED;
          end else begin
            state <= FETCH;
          end
        end
        default: begin
          read  <= 1'b0;
          write <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hmmm.sv
`default_nettype none
// ============================================================================
// tb_hmmm : directed self-checking bench for the hmmm CPU
// Rev 1.0
// ============================================================================
module tb_hmmm;

  logic        clk;
  logic        rst;
  logic        pgrm_addr;
  logic        pgrm_data;
  logic        read;
  logic        write;
  logic [15:0] in;
  logic [15:0] out;
  logic        halt;

  hmmm dut (
    .clk       (clk),
    .rst       (rst),
    .pgrm_addr (pgrm_addr),
    .pgrm_data (pgrm_data),
    .read      (read),
    .write     (write),
    .in        (in),
    .out       (out),
    .halt      (halt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          total = 0;
  int          bad   = 0;
  int          nwr;
  int          nrd;
  int          hcyc;
  int          rd_cyc;
  logic [15:0] wr_vals [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_word(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pgrm_addr = 1'b1;
    pgrm_data = 1'b0;
    in        = {8'h00, a};
    @(negedge clk);
    pgrm_addr = 1'b0;
    pgrm_data = 1'b1;
    in        = d;
    @(negedge clk);
    pgrm_data = 1'b0;
    in        = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input logic [15:0] din, input int budget);
    nwr    = 0;
    nrd    = 0;
    hcyc   = -1;
    rd_cyc = -1;
    in     = din;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (write) begin
        if (nwr < 16) wr_vals[nwr] = out;
        nwr++;
      end
      if (read) begin
        nrd++;
        if (rd_cyc < 0) rd_cyc = c;
      end
      if (halt) begin
        hcyc = c;
        break;
      end
    end
  endtask

  task automatic load_call_prog();
    load_word(8'd0,  16'h1F64);
    load_word(8'd1,  16'h0101);
    load_word(8'd2,  16'hBE07);
    load_word(8'd3,  16'h0D02);
    load_word(8'd4,  16'h0000);
    load_word(8'd5,  16'h6D11);
    load_word(8'd6,  16'h0E03);
    load_word(8'd7,  16'h4EF3);
    load_word(8'd8,  16'hBE05);
    load_word(8'd9,  16'h4EF2);
    load_word(8'd10, 16'h61D0);
    load_word(8'd11, 16'h4EF3);
    load_word(8'd12, 16'hBE05);
    load_word(8'd13, 16'h4EF2);
    load_word(8'd14, 16'h0E03);
  endtask

  initial begin
    rst       = 1'b0;
    pgrm_addr = 1'b0;
    pgrm_data = 1'b0;
    in        = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_halt",  {31'b0, halt},  32'd0);
    chk("rst_read",  {31'b0, read},  32'd0);
    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_out",   {16'b0, out},   32'd0);

    // Call/return program, input 42 -> 4*42
    load_call_prog();
    run(16'd42, 200);
    chk("t1_halt_cyc", hcyc,   32'd34);
    chk("t1_nwr",      nwr,    32'd1);
    chk("t1_out",      {16'b0, wr_vals[0]}, 32'd168);
    chk("t1_nrd",      nrd,    32'd1);
    chk("t1_rd_cyc",   rd_cyc, 32'd3);

    // Same RAM image rerun with a negative input
    do_reset();
    run(16'hFFFB, 200);
    chk("t2_halt_cyc", hcyc, 32'd34);
    chk("t2_nwr",      nwr,  32'd1);
    chk("t2_out",      {16'b0, wr_vals[0]}, 32'h0000FFEC);

    // Asynchronous reset from HALTED, then identical rerun
    @(negedge clk);
    chk("t6_pre_halt", {31'b0, halt}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_halt",  {31'b0, halt},  32'd0);
    chk("t6_read",  {31'b0, read},  32'd0);
    chk("t6_write", {31'b0, write}, 32'd0);
    chk("t6_out",   {16'b0, out},   32'd0);
    run(16'd42, 200);
    chk("t6_halt_cyc", hcyc, 32'd34);
    chk("t6_rerun_out", {16'b0, wr_vals[0]}, 32'd168);

    // setn/addn sign extension and r0 write discard
    do_reset();
    load_word(8'd0, 16'h1180);
    load_word(8'd1, 16'h51FF);
    load_word(8'd2, 16'h0102);
    load_word(8'd3, 16'h1007);
    load_word(8'd4, 16'h0002);
    load_word(8'd5, 16'h0000);
    run(16'h0000, 100);
    chk("t3_halt_cyc", hcyc, 32'd12);
    chk("t3_nwr",  nwr, 32'd2);
    chk("t3_addn", {16'b0, wr_vals[0]}, 32'h0000FF7F);
    chk("t3_r0",   {16'b0, wr_vals[1]}, 32'h00000000);

    // div/mod incl. divide by zero, mul, sub
    do_reset();
    load_word(8'd0,  16'h1107);
    load_word(8'd1,  16'h12FE);
    load_word(8'd2,  16'h9312);
    load_word(8'd3,  16'hA412);
    load_word(8'd4,  16'h0302);
    load_word(8'd5,  16'h0402);
    load_word(8'd6,  16'h1200);
    load_word(8'd7,  16'h9312);
    load_word(8'd8,  16'hA412);
    load_word(8'd9,  16'h0302);
    load_word(8'd10, 16'h0402);
    load_word(8'd11, 16'h11F9);
    load_word(8'd12, 16'h1202);
    load_word(8'd13, 16'h9312);
    load_word(8'd14, 16'hA412);
    load_word(8'd15, 16'h0302);
    load_word(8'd16, 16'h0402);
    load_word(8'd17, 16'h8512);
    load_word(8'd18, 16'h0502);
    load_word(8'd19, 16'h7601);
    load_word(8'd20, 16'h0602);
    load_word(8'd21, 16'h0000);
    run(16'h0000, 200);
    chk("t4_halt_cyc", hcyc, 32'd44);
    chk("t4_nwr", nwr, 32'd8);
    chk("t4_div_7_m2",  {16'b0, wr_vals[0]}, 32'h0000FFFD);
    chk("t4_mod_7_m2",  {16'b0, wr_vals[1]}, 32'h00000001);
    chk("t4_div_zero",  {16'b0, wr_vals[2]}, 32'h00000000);
    chk("t4_mod_zero",  {16'b0, wr_vals[3]}, 32'h00000000);
    chk("t4_div_m7_2",  {16'b0, wr_vals[4]}, 32'h0000FFFD);
    chk("t4_mod_m7_2",  {16'b0, wr_vals[5]}, 32'h0000FFFF);
    chk("t4_mul",       {16'b0, wr_vals[6]}, 32'h0000FFF2);
    chk("t4_sub",       {16'b0, wr_vals[7]}, 32'h00000007);

    // Conditional branches: taken ones skip writes, untaken ones fall through
    do_reset();
    load_word(8'd0,  16'h1100);
    load_word(8'd1,  16'hC104);
    load_word(8'd2,  16'h1201);
    load_word(8'd3,  16'h0202);
    load_word(8'd4,  16'hD114);
    load_word(8'd5,  16'h1333);
    load_word(8'd6,  16'h0302);
    load_word(8'd7,  16'h11FF);
    load_word(8'd8,  16'hF10B);
    load_word(8'd9,  16'h1444);
    load_word(8'd10, 16'h0402);
    load_word(8'd11, 16'hE114);
    load_word(8'd12, 16'h1555);
    load_word(8'd13, 16'h0502);
    load_word(8'd14, 16'h0000);
    load_word(8'd20, 16'h1666);
    load_word(8'd21, 16'h0602);
    load_word(8'd22, 16'h0000);
    run(16'h0000, 200);
    chk("t5_halt_cyc", hcyc, 32'd22);
    chk("t5_nwr", nwr, 32'd2);
    chk("t5_first",  {16'b0, wr_vals[0]}, 32'h00000033);
    chk("t5_second", {16'b0, wr_vals[1]}, 32'h00000055);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
